// File: rtl/dso_capture_pkg.sv
// rtl/dso_capture_pkg.sv - shared state encoding and trigger-select width for the DSO capture engine
package dso_capture_pkg;

  localparam int TRIG_SRC_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } dso_state_t;

endpackage

// File: rtl/dso_sample_ram.sv
// rtl/dso_sample_ram.sv - simple dual-port sample RAM, one write port and one registered read port
module dso_sample_ram
  import dso_capture_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  // No reset on the array or the read register so the tools map this onto block RAM.
  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dso_capture.sv
// rtl/dso_capture.sv - triggered multi-channel acquisition into a circular RAM, frozen for readout on completion
module dso_capture
  import dso_capture_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int DW   = 8,
  parameter int AW   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*DW-1:0]    adc_d,
  input  logic                  arm,
  input  logic [15:0]           decim,
  input  logic [AW-1:0]         pretrig,
  input  logic [TRIG_SRC_W-1:0] trig_src,
  input  logic [DW-1:0]         trig_level,
  input  logic                  trig_rising,
  input  logic                  trig_force,
  input  logic [AW-1:0]         rd_addr,
  output logic [N_CH*DW-1:0]    rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         start_addr
);

  localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_V   = {{AW{1'b0}}, 1'b1};

  dso_state_t               state, state_n;
  logic [N_CH*DW-1:0]       adc_q;
  logic [15:0]              dcnt;
  logic [AW-1:0]            wptr, trig_addr, pre_q;
  logic [AW:0]              scnt, scnt_inc, post_len;
  logic [TRIG_SRC_W-1:0]    src_q;
  logic [DW-1:0]            level_q, prev_s, trig_cur;
  logic                     rising_q, force_lat, prev_valid;
  logic                     capturing, arm_ok, strobe, edge_hit, trig_hit;

  assign capturing = (state == ST_PRE) || (state == ST_WAIT_TRIG) || (state == ST_POST);
  assign arm_ok    = arm && ((state == ST_IDLE) || (state == ST_DONE));
  assign strobe    = capturing && (dcnt == '0);
  assign scnt_inc  = scnt + 1'b1;
  assign post_len  = DEPTH_V - {1'b0, pre_q};
  assign busy      = capturing;
  assign done      = (state == ST_DONE);

  always_comb begin
    trig_cur = adc_q[DW-1:0];
    for (int c = 0; c < N_CH; c++)
      if (int'(src_q) == c) trig_cur = adc_q[c*DW +: DW];
  end

  assign edge_hit = prev_valid &&
                    (rising_q ? ((prev_s < level_q) && (trig_cur >= level_q))
                              : ((prev_s > level_q) && (trig_cur <= level_q)));

  always_comb begin
    state_n  = state;
    trig_hit = 1'b0;
    case (state)
      ST_IDLE, ST_DONE:
        if (arm) state_n = (pretrig == '0) ? ST_WAIT_TRIG : ST_PRE;
      ST_PRE:
        if (strobe && (scnt_inc == {1'b0, pre_q})) state_n = ST_WAIT_TRIG;
      ST_WAIT_TRIG:
        if (strobe && (force_lat || trig_force || edge_hit)) begin
          trig_hit = 1'b1;
          state_n  = (post_len == ONE_V) ? ST_DONE : ST_POST;
        end
      ST_POST:
        if (strobe && (scnt_inc == post_len)) state_n = ST_DONE;
      default:
        state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      adc_q      <= '0;
      dcnt       <= '0;
      wptr       <= '0;
      scnt       <= '0;
      pre_q      <= '0;
      src_q      <= '0;
      level_q    <= '0;
      rising_q   <= 1'b0;
      force_lat  <= 1'b0;
      prev_s     <= '0;
      prev_valid <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
    end else begin
      state <= state_n;
      adc_q <= adc_d;
      if (arm_ok) begin
        // pretrig is AW bits wide, so it is already bounded by DEPTH-1.
        dcnt       <= '0;
        wptr       <= '0;
        scnt       <= '0;
        pre_q      <= pretrig;
        src_q      <= trig_src;
        level_q    <= trig_level;
        rising_q   <= trig_rising;
        force_lat  <= 1'b0;
        prev_valid <= 1'b0;
      end else if (capturing) begin
        dcnt <= (dcnt == decim) ? '0 : dcnt + 1'b1;
        if ((state == ST_PRE) && trig_force) force_lat <= 1'b1;
        if (strobe) begin
          wptr       <= wptr + 1'b1;
          prev_s     <= trig_cur;
          prev_valid <= 1'b1;
          scnt       <= trig_hit ? ONE_V : scnt_inc;
          if (trig_hit) trig_addr <= wptr;
        end
        if (state_n == ST_DONE)
          start_addr <= (trig_hit ? wptr : trig_addr) - pre_q;
      end
    end
  end

  dso_sample_ram #(.W(N_CH*DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (strobe),
    .waddr (wptr),
    .wdata (adc_q),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_dso_capture.sv
// tb/tb_dso_capture.sv - directed self-checking bench for dso_capture at DEPTH 16, two 8-bit channels
module tb_dso_capture;

  localparam int N_CH = 2;
  localparam int DW   = 8;
  localparam int AW   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] adc_d;
  logic        arm;
  logic [15:0] decim;
  logic [3:0]  pretrig;
  logic [1:0]  trig_src;
  logic [7:0]  trig_level;
  logic        trig_rising;
  logic        trig_force;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic [3:0]  start_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dso_capture #(.N_CH(N_CH), .DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .adc_d       (adc_d),
    .arm         (arm),
    .decim       (decim),
    .pretrig     (pretrig),
    .trig_src    (trig_src),
    .trig_level  (trig_level),
    .trig_rising (trig_rising),
    .trig_force  (trig_force),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .start_addr  (start_addr)
  );

  // Sample k is the adc_d value present just before the k-th clock edge after arm.
  function automatic logic [15:0] sample(input int mode, input int k);
    logic [7:0] b;
    b = 8'(k);
    case (mode)
      0:       sample = {8'h00, 8'(k * 16)};
      1:       sample = {(k < 5) ? 8'h80 : 8'h20, (k < 3) ? 8'h80 : 8'h10};
      2:       sample = 16'h5555;
      default: sample = {~b, b};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_capture(input int mode, input int rearm_k, input int force_k,
                             input int force_end, input int limit,
                             output int cyc, output bit busy_ok);
    cyc     = -1;
    busy_ok = 1'b1;
    for (int k = 0; k <= limit; k++) begin
      adc_d      = sample(mode, k);
      arm        = (k == 0) || (k == rearm_k);
      trig_force = (force_k >= 0) && (k >= force_k) && (k < force_end);
      tick();
      arm = 1'b0;
      if (done) begin
        cyc = k;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    trig_force = 1'b0;
  endtask

  task automatic read_word(input logic [3:0] a, output logic [15:0] d);
    rd_addr = a;
    adc_d   = ~adc_d;
    tick();
    d = rd_data;
  endtask

  task automatic setup(input logic [15:0] dc, input logic [3:0] pt, input logic [1:0] src,
                       input logic [7:0] lvl, input logic rise);
    decim       = dc;
    pretrig     = pt;
    trig_src    = src;
    trig_level  = lvl;
    trig_rising = rise;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arm = 1'b0; trig_force = 1'b0; adc_d = '0; rd_addr = '0;
    setup(16'd0, 4'd0, 2'd0, 8'h00, 1'b1);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (start_addr !== 4'd0) begin errors++; $display("FAIL reset_start: got %0d expected 0", start_addr); end
  endtask

  task automatic test_rising_edge();
    int cyc; bit bok; logic [15:0] d;
    setup(16'd0, 4'd4, 2'd0, 8'h80, 1'b1);
    run_capture(0, -1, -1, 0, 100, cyc, bok);
    checks++; if (cyc !== 20) begin errors++; $display("FAIL rise_cycles: got %0d expected 20", cyc); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL rise_busy: busy/done overlap or gap, got %b expected 1", bok); end
    checks++; if (start_addr !== 4'd4) begin errors++; $display("FAIL rise_start: got %0d expected 4", start_addr); end
    read_word(4'd4, d);
    checks++; if (d[7:0] !== 8'h40) begin errors++; $display("FAIL rise_rd4: got %h expected 40", d[7:0]); end
    read_word(4'd3, d);
    checks++; if (d[7:0] !== 8'h30) begin errors++; $display("FAIL rise_rd3: got %h expected 30", d[7:0]); end
    read_word(4'd8, d);
    checks++; if (d !== 16'h0080) begin errors++; $display("FAIL rise_rd8: got %h expected 0080", d); end
  endtask

  task automatic test_falling_ch1();
    int cyc; bit bok; logic [15:0] d;
    setup(16'd0, 4'd2, 2'd1, 8'h40, 1'b0);
    run_capture(1, -1, -1, 0, 100, cyc, bok);
    checks++; if (cyc !== 19) begin errors++; $display("FAIL fall_cycles: got %0d expected 19", cyc); end
    checks++; if (start_addr !== 4'd3) begin errors++; $display("FAIL fall_start: got %0d expected 3", start_addr); end
    read_word(4'd5, d);
    checks++; if (d !== 16'h2010) begin errors++; $display("FAIL fall_rd5: got %h expected 2010", d); end
    read_word(4'd4, d);
    checks++; if (d !== 16'h8010) begin errors++; $display("FAIL fall_rd4: got %h expected 8010", d); end
  endtask

  task automatic test_reset_mid_post();
    int cyc; bit bok; logic [15:0] d;
    setup(16'd0, 4'd4, 2'd0, 8'h80, 1'b1);
    for (int k = 0; k <= 12; k++) begin
      adc_d = sample(0, k);
      arm   = (k == 0);
      tick();
      arm = 1'b0;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (start_addr !== 4'd0) begin errors++; $display("FAIL rst_start: got %0d expected 0", start_addr); end
    #2 rst_n = 1'b1;
    tick();
    run_capture(0, -1, -1, 0, 100, cyc, bok);
    checks++; if (cyc !== 20) begin errors++; $display("FAIL rst_recap_cycles: got %0d expected 20", cyc); end
    checks++; if (start_addr !== 4'd4) begin errors++; $display("FAIL rst_recap_start: got %0d expected 4", start_addr); end
    read_word(4'd4, d);
    checks++; if (d !== 16'h0040) begin errors++; $display("FAIL rst_recap_rd4: got %h expected 0040", d); end
  endtask

  task automatic test_forced();
    int cyc; bit bok; logic [15:0] d;
    setup(16'd0, 4'd0, 2'd0, 8'h00, 1'b1);
    run_capture(2, -1, 0, 1000, 100, cyc, bok);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL force_cycles: got %0d expected 16", cyc); end
    checks++; if (start_addr !== 4'd0) begin errors++; $display("FAIL force_start: got %0d expected 0", start_addr); end
    read_word(4'd15, d);
    checks++; if (d !== 16'h5555) begin errors++; $display("FAIL force_rd15: got %h expected 5555", d); end
  endtask

  task automatic test_force_latch();
    int cyc; bit bok; logic [15:0] d;
    setup(16'd0, 4'd3, 2'd0, 8'hFF, 1'b1);
    run_capture(3, -1, 1, 2, 100, cyc, bok);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL latch_cycles: got %0d expected 16", cyc); end
    checks++; if (start_addr !== 4'd0) begin errors++; $display("FAIL latch_start: got %0d expected 0", start_addr); end
    read_word(4'd3, d);
    checks++; if (d !== 16'hFC03) begin errors++; $display("FAIL latch_rd3: got %h expected fc03", d); end
  endtask

  task automatic test_decimation();
    int cyc; bit bok; logic [15:0] d;
    setup(16'd3, 4'd0, 2'd0, 8'h00, 1'b1);
    run_capture(3, -1, 0, 1000, 200, cyc, bok);
    checks++; if (cyc !== 61) begin errors++; $display("FAIL decim_cycles: got %0d expected 61", cyc); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL decim_busy: got %b expected 1", bok); end
    read_word(4'd5, d);
    checks++; if (d !== 16'hEB14) begin errors++; $display("FAIL decim_rd5: got %h expected eb14", d); end
    read_word(4'd15, d);
    checks++; if (d !== 16'hC33C) begin errors++; $display("FAIL decim_rd15: got %h expected c33c", d); end
    decim = 16'd0;
  endtask

  task automatic test_arm_while_busy();
    int cyc; bit bok; logic [15:0] d;
    setup(16'd0, 4'd2, 2'd0, 8'hFF, 1'b1);
    run_capture(3, 6, 10, 1000, 100, cyc, bok);
    checks++; if (cyc !== 23) begin errors++; $display("FAIL rearm_cycles: got %0d expected 23", cyc); end
    checks++; if (start_addr !== 4'd7) begin errors++; $display("FAIL rearm_start: got %0d expected 7", start_addr); end
    read_word(4'd7, d);
    checks++; if (d !== 16'hF807) begin errors++; $display("FAIL rearm_rd7: got %h expected f807", d); end
  endtask

  task automatic test_pretrig_max();
    int cyc; bit bok; logic [15:0] d;
    setup(16'd0, 4'd15, 2'd0, 8'h20, 1'b1);
    run_capture(3, -1, -1, 0, 100, cyc, bok);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL pmax_cycles: got %0d expected 33", cyc); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL pmax_busy: got %b expected 1", bok); end
    checks++; if (start_addr !== 4'd1) begin errors++; $display("FAIL pmax_start: got %0d expected 1", start_addr); end
    read_word(4'd0, d);
    checks++; if (d !== 16'hDF20) begin errors++; $display("FAIL pmax_rd0: got %h expected df20", d); end
    read_word(4'd1, d);
    checks++; if (d !== 16'hEE11) begin errors++; $display("FAIL pmax_rd1: got %h expected ee11", d); end
  endtask

  initial begin
    test_reset();
    test_rising_edge();
    test_falling_ch1();
    test_reset_mid_post();
    test_forced();
    test_force_latch();
    test_decimation();
    test_arm_while_busy();
    test_pretrig_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
